// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - APB initiator bridging a cmd/rsp handshake onto the PCLK bus.
// Optional ACCESS-phase timeout is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_if #(
    parameter int ADDRESSWIDTH   = 4,
    parameter int DATAWIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESSWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0]    cmd_wdata,
    output logic                    rsp_valid,
    output logic [DATAWIDTH-1:0]    rsp_rdata,
    output logic                    rsp_error,
    output logic                    busy,
    output logic [ADDRESSWIDTH-1:0] PADDR,
    output logic [DATAWIDTH-1:0]    PWDATA,
    output logic                    PWRITE,
    output logic                    PSELx,
    output logic                    PENABLE,
    input  logic [DATAWIDTH-1:0]    PRDATA,
    input  logic                    PREADY
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   complete;
    logic   abort;

    assign cmd_ready = PRESETn & ((state == IDLE) | ((state == ACCESS) & PREADY));
    assign accept    = cmd_valid & cmd_ready;
    assign complete  = (state == ACCESS) & PREADY;

    assign PSELx   = (state == SETUP) | (state == ACCESS);
    assign PENABLE = (state == ACCESS);
    assign busy    = PSELx;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          rsp_error_q;

    // Abort on the edge that would make the count reach the limit, so ACCESS
    // lasts exactly TIMEOUT_CYCLES cycles when PREADY never rises.
    assign abort     = (state == ACCESS) & ~PREADY & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign rsp_error = rsp_error_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt    <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            rsp_error_q <= abort;
            if (state != ACCESS)
                wait_cnt <= '0;
            else if (!PREADY)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign abort = 1'b0;
    // TIMEOUT_CYCLES only shapes the timeout build; here the flag is tied low.
    assign rsp_error = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = SETUP;
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (complete)
                    state_nxt = accept ? SETUP : IDLE;
                else if (abort)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= complete | abort;
            if (complete)
                rsp_rdata <= PWRITE ? '0 : PRDATA;
            else if (abort)
                rsp_rdata <= '0;
            // A completion edge may also accept the next command (ACCESS->SETUP).
            if (accept) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                PWDATA <= cmd_write ? cmd_wdata : '0;
            end else if (complete | abort) begin
                PWDATA <= '0;
            end
        end
    end

endmodule

// File: doc/apb_master_if.md
Name: apb_master_if

Overview:
- APB initiator that drives the APB slave's PCLK-domain bus from a simple command/response handshake.
- Serves as the bus-side counterpart of the slave: a controller, or the system bench, issues register writes (reg_command, reg_temp, reg_pres) and reads (reg_status, reg_receive) through it.
- One transfer outstanding at a time; back-to-back transfers go ACCESS->SETUP with no idle cycle.

Parameters:
- ADDRESSWIDTH, 4, width of PADDR / cmd_addr
- DATAWIDTH, 8, width of PWDATA / PRDATA / cmd_wdata / rsp_rdata
- TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for PREADY (used only with the optional feature; minimum 1)

Ports:
- PCLK  input  1  bus clock; the only clock
- PRESETn  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a PCLK rising edge
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDRESSWIDTH  target address
- cmd_wdata  input  DATAWIDTH  write data
- rsp_valid  output  1  one-cycle pulse: transfer complete
- rsp_rdata  output  DATAWIDTH  read data; valid with rsp_valid on reads, 0 on writes
- rsp_error  output  1  transfer aborted by timeout; qualified by rsp_valid
- busy  output  1  high in SETUP or ACCESS
- PADDR  output  ADDRESSWIDTH  APB address
- PWDATA  output  DATAWIDTH  APB write data
- PWRITE  output  1  APB direction
- PSELx  output  1  APB select
- PENABLE  output  1  APB enable
- PRDATA  input  DATAWIDTH  APB read data
- PREADY  input  1  APB ready

Behaviour:
- Reset: PRESETn low asynchronously forces state IDLE. All outputs are 0 (PADDR, PWDATA, PWRITE, PSELx, PENABLE, rsp_valid, rsp_rdata, rsp_error, busy), except cmd_ready, which is held 0 while PRESETn is low.
- States:
  - IDLE: PSELx=0, PENABLE=0.
  - SETUP: PSELx=1, PENABLE=0.
  - ACCESS: PSELx=1, PENABLE=1.
- cmd_ready (combinational) = PRESETn & ((state==IDLE) | (state==ACCESS & PREADY)).
- Accept: cmd_addr, cmd_write and cmd_wdata are registered into PADDR, PWRITE and PWDATA; next state is SETUP. On reads, PWDATA is 0.
- SETUP -> ACCESS unconditionally after 1 cycle.
- ACCESS with PREADY=0: stay in ACCESS. PADDR, PWRITE, PWDATA, PSELx and PENABLE are held stable.
- ACCESS with PREADY=1 (completion edge):
  - Read: PRDATA is captured into rsp_rdata.
  - rsp_valid=1 for exactly the next cycle.
  - Next state is SETUP if a new command is accepted in that same cycle, else IDLE.
- rsp_rdata is 0 for write responses and holds its value until the next response.
- Latency: accept at edge N gives PSELx=1 in cycle N+1 and PENABLE=1 in cycle N+2. With PREADY=1 in N+2, rsp_valid=1 in N+3. Throughput is 2 cycles per transfer when cmd_valid is held.
- When idle, PADDR and PWRITE keep their last values; PWDATA returns to 0.
- PREADY and PRDATA are ignored outside ACCESS.
- cmd_valid while busy (and not at the completion edge) is not accepted; the requester must hold its command.
- Reset asserted mid-transfer: the bus drops immediately and no rsp_valid is issued for the aborted transfer.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entering ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES, the transfer is abandoned: next state IDLE, PSELx=PENABLE=0, rsp_valid=1 with rsp_error=1 and rsp_rdata=0.
  - cmd_ready stays 0 on the abort edge.
  - PREADY=1 on the same cycle as the counter reaching its limit counts as normal completion; error is not flagged.
- Without the macro: ACCESS waits indefinitely, rsp_error is constant 0, and no counter logic exists.

Test Plan:
1. Reset, then write addr 0x2 data 0xA5 with PREADY tied 1 -> PSELx at N+1, PENABLE at N+2, PADDR=0x2, PWDATA=0xA5, PWRITE=1; rsp_valid pulse at N+3, rsp_rdata=0x00.
2. Read addr 0x0, PREADY low for 3 ACCESS cycles, then high with PRDATA=0x3C -> bus signals stable through the wait; rsp_valid=1, rsp_rdata=0x3C; busy drops the cycle after completion.
3. Two writes (0x3/0x11, 0x4/0x22) with cmd_valid held -> second SETUP immediately follows first ACCESS with no IDLE cycle; two rsp_valid pulses 2 cycles apart.
4. PRESETn pulsed low during ACCESS -> PSELx, PENABLE and busy go 0 without waiting for a clock edge; no rsp_valid; next command after reset completes normally.
5. APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 ACCESS cycles with rsp_valid=1, rsp_error=1, rsp_rdata=0, state IDLE. Repeat with PREADY=1 on the 4th cycle -> rsp_error=0.
6. cmd_valid asserted during SETUP -> cmd_ready=0; command accepted only at the ACCESS completion edge; PADDR changes only after that edge.
